// File: rtl/pc_sequencer_if.sv
// Bus between hazard/branch logic (master) and the next-PC sequencer (slave).
// valid/ready: none; every signal is a level sampled or produced in the same cycle.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

interface pc_sequencer_if #(
  parameter int ADDR_W = `IM_ADDR_BIT,
  parameter int CNT_W  = 32
);
  logic              mem_wait;
  logic              halt_req;
  logic [ADDR_W-1:0] halt_pc;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_tgt;
  logic              load_use;
  logic              jump;
  logic [ADDR_W-1:0] jump_tgt;
  logic              resume;
  logic              cnt_clr;
  logic [ADDR_W-1:0] pc_4;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_new;
  logic              hold_ifid;
  logic              flush_if;
  logic              flush_id;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  redir_cnt;
  logic              state_dbg;

  modport master (
    output mem_wait, halt_req, halt_pc, branch_taken, branch_tgt, load_use,
           jump, jump_tgt, resume, cnt_clr, pc_4,
    input  pc_en, pc_new, hold_ifid, flush_if, flush_id, halted,
           stall_cnt, redir_cnt, state_dbg
  );

  modport slave (
    input  mem_wait, halt_req, halt_pc, branch_taken, branch_tgt, load_use,
           jump, jump_tgt, resume, cnt_clr, pc_4,
    output pc_en, pc_new, hold_ifid, flush_if, flush_id, halted,
           stall_cnt, redir_cnt, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects pc_new/pc_en from redirects, hazards and halt/resume,
// drives pipeline hold/flush strobes and keeps saturating stall/redirect counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module pc_sequencer #(
  parameter int ADDR_W = `IM_ADDR_BIT,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] saved_pc;
  logic              save_halt_pc;
  logic              stall_inc;
  logic              redir_inc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  redir_cnt;

  // Priority chain: the first matching row owns every output this cycle.
  always_comb begin
    state_nxt     = state;
    bus.pc_en     = 1'b0;
    bus.pc_new    = bus.pc_4;
    bus.hold_ifid = 1'b0;
    bus.flush_if  = 1'b0;
    bus.flush_id  = 1'b0;
    save_halt_pc  = 1'b0;
    redir_inc     = 1'b0;
    if (state == S_RUN) begin
      if (bus.mem_wait) begin
        bus.hold_ifid = 1'b1;
      end else if (bus.halt_req) begin
        bus.flush_if = 1'b1;
        bus.flush_id = 1'b1;
        save_halt_pc = 1'b1;
        state_nxt    = S_HALT;
      end else if (bus.branch_taken) begin
        bus.pc_en    = 1'b1;
        bus.pc_new   = bus.branch_tgt;
        bus.flush_if = 1'b1;
        bus.flush_id = 1'b1;
        redir_inc    = 1'b1;
      end else if (bus.load_use) begin
        bus.hold_ifid = 1'b1;
        bus.flush_id  = 1'b1;
      end else if (bus.jump) begin
        bus.pc_en    = 1'b1;
        bus.pc_new   = bus.jump_tgt;
        bus.flush_if = 1'b1;
        redir_inc    = 1'b1;
      end else begin
        bus.pc_en = 1'b1;
      end
    end else begin
      if (bus.resume) begin
        bus.pc_en    = 1'b1;
        bus.pc_new   = saved_pc;
        bus.flush_if = 1'b1;
        state_nxt    = S_RUN;
      end else begin
        bus.hold_ifid = 1'b1;
      end
    end
  end

  // Counters only advance in RUN, so they are frozen throughout HALT.
  assign stall_inc = (state == S_RUN) && !bus.pc_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      saved_pc  <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (save_halt_pc) saved_pc <= bus.halt_pc;
      if (bus.cnt_clr) begin
        stall_cnt <= '0;
        redir_cnt <= '0;
      end else begin
        if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
        if (redir_inc && (redir_cnt != {CNT_W{1'b1}})) redir_cnt <= redir_cnt + 1'b1;
      end
    end
  end

  assign bus.halted    = (state == S_HALT);
  assign bus.stall_cnt = stall_cnt;
  assign bus.redir_cnt = redir_cnt;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer built with a 4-bit counter width.
module tb_pc_sequencer;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.mem_wait = 0; bus.halt_req = 0; bus.halt_pc = '0; bus.branch_taken = 0;
    bus.branch_tgt = '0; bus.load_use = 0; bus.jump = 0; bus.jump_tgt = '0;
    bus.resume = 0; bus.cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.pc_4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    compared++; if (bus.halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %0h want 0", bus.halted); end
    compared++; if (bus.stall_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); end
    compared++; if (bus.redir_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_redir: got %0d want 0", bus.redir_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.pc_4 = ADDR_W'(i);
      #1;
      compared++; if (bus.pc_en !== 1'b1) begin mismatched++; $display("FAIL idle_pc_en[%0d]: got %0h want 1", i, bus.pc_en); end
      compared++; if (bus.pc_new !== ADDR_W'(i)) begin mismatched++; $display("FAIL idle_pc_new[%0d]: got %0h want %0h", i, bus.pc_new, i); end
    end
    @(negedge clk); #1;
    compared++; if (bus.stall_cnt !== 4'd0) begin mismatched++; $display("FAIL idle_stall: got %0d want 0", bus.stall_cnt); end
    compared++; if (bus.redir_cnt !== 4'd0) begin mismatched++; $display("FAIL idle_redir: got %0d want 0", bus.redir_cnt); end
  endtask

  task automatic test_load_use_jump();
    @(negedge clk);
    bus.pc_4 = 10'h005; bus.load_use = 1; bus.jump = 1; bus.jump_tgt = 10'h040;
    #1;
    compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b0101) begin mismatched++;
      $display("FAIL lu_strobes: got %b want 0101", {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    @(negedge clk);
    bus.load_use = 0;
    #1;
    compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b1010) begin mismatched++;
      $display("FAIL jump_strobes: got %b want 1010", {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    compared++; if (bus.pc_new !== 10'h040) begin mismatched++; $display("FAIL jump_pc_new: got %0h want 40", bus.pc_new); end
    @(negedge clk);
    bus.jump = 0;
    #1;
    compared++; if (bus.stall_cnt !== 4'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
    compared++; if (bus.redir_cnt !== 4'd1) begin mismatched++; $display("FAIL jump_redir_cnt: got %0d want 1", bus.redir_cnt); end
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    bus.branch_taken = 1; bus.branch_tgt = 10'h010; bus.load_use = 1; bus.jump = 1; bus.jump_tgt = 10'h020;
    #1;
    compared++; if (bus.pc_new !== 10'h010) begin mismatched++; $display("FAIL br_pc_new: got %0h want 10", bus.pc_new); end
    compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b1011) begin mismatched++;
      $display("FAIL br_strobes: got %b want 1011", {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    @(negedge clk);
    idle_inputs();
    #1;
    compared++; if (bus.redir_cnt !== 4'd2) begin mismatched++; $display("FAIL br_redir_cnt: got %0d want 2", bus.redir_cnt); end
    compared++; if (bus.stall_cnt !== 4'd1) begin mismatched++; $display("FAIL br_stall_cnt: got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_mem_wait_halt_resume();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_wait = 1; bus.halt_req = 1; bus.halt_pc = 10'h3ff;
      #1;
      compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b0100) begin mismatched++;
        $display("FAIL mw_strobes[%0d]: got %b want 0100", i, {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
      compared++; if (bus.state_dbg !== 1'b0) begin mismatched++; $display("FAIL mw_state[%0d]: got %0h want 0", i, bus.state_dbg); end
    end
    @(negedge clk);
    bus.mem_wait = 0; bus.halt_pc = 10'h025;
    #1;
    compared++; if (bus.stall_cnt !== 4'd4) begin mismatched++; $display("FAIL mw_stall_cnt: got %0d want 4", bus.stall_cnt); end
    compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b0011) begin mismatched++;
      $display("FAIL halt_strobes: got %b want 0011", {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    compared++; if (bus.halted !== 1'b0) begin mismatched++; $display("FAIL halt_not_yet: got %0h want 0", bus.halted); end
    @(negedge clk);
    bus.halt_req = 0;
    #1;
    compared++; if (bus.halted !== 1'b1) begin mismatched++; $display("FAIL halted_set: got %0h want 1", bus.halted); end
    compared++; if (bus.stall_cnt !== 4'd5) begin mismatched++; $display("FAIL halt_stall_cnt: got %0d want 5", bus.stall_cnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.branch_taken = (i == 2); bus.branch_tgt = 10'h111; bus.jump = (i == 3); bus.jump_tgt = 10'h222;
      #1;
      compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b0100) begin mismatched++;
        $display("FAIL halt_idle[%0d]: got %b want 0100", i, {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    end
    @(negedge clk);
    bus.branch_taken = 0; bus.jump = 0; bus.resume = 1;
    #1;
    compared++; if (bus.stall_cnt !== 4'd5 || bus.redir_cnt !== 4'd2) begin mismatched++;
      $display("FAIL halt_frozen: got %0d/%0d want 5/2", bus.stall_cnt, bus.redir_cnt); end
    compared++; if (bus.pc_new !== 10'h025) begin mismatched++; $display("FAIL resume_pc_new: got %0h want 25", bus.pc_new); end
    compared++; if ({bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id} !== 4'b1010) begin mismatched++;
      $display("FAIL resume_strobes: got %b want 1010", {bus.pc_en, bus.hold_ifid, bus.flush_if, bus.flush_id}); end
    @(negedge clk);
    bus.pc_4 = 10'h026;
    #1;
    compared++; if (bus.halted !== 1'b0) begin mismatched++; $display("FAIL resume_halted: got %0h want 0", bus.halted); end
    compared++; if (bus.pc_en !== 1'b1 || bus.pc_new !== 10'h026 || bus.flush_if !== 1'b0) begin mismatched++;
      $display("FAIL resume_in_run: got en=%0h pc=%0h fi=%0h want 1/26/0", bus.pc_en, bus.pc_new, bus.flush_if); end
    bus.resume = 0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    bus.cnt_clr = 1;
    @(negedge clk);
    bus.cnt_clr = 0;
    #1;
    compared++; if (bus.stall_cnt !== 4'd0 || bus.redir_cnt !== 4'd0) begin mismatched++;
      $display("FAIL clr: got %0d/%0d want 0/0", bus.stall_cnt, bus.redir_cnt); end
    bus.load_use = 1;
    repeat (20) @(negedge clk);
    #1;
    compared++; if (bus.stall_cnt !== 4'd15) begin mismatched++; $display("FAIL stall_sat: got %0d want 15", bus.stall_cnt); end
    bus.load_use = 0; bus.jump = 1; bus.jump_tgt = 10'h030;
    repeat (20) @(negedge clk);
    #1;
    compared++; if (bus.redir_cnt !== 4'd15) begin mismatched++; $display("FAIL redir_sat: got %0d want 15", bus.redir_cnt); end
    compared++; if (bus.stall_cnt !== 4'd15) begin mismatched++; $display("FAIL stall_hold: got %0d want 15", bus.stall_cnt); end
    bus.load_use = 1; bus.cnt_clr = 1;
    @(negedge clk);
    idle_inputs();
    #1;
    compared++; if (bus.stall_cnt !== 4'd0 || bus.redir_cnt !== 4'd0) begin mismatched++;
      $display("FAIL clr_wins: got %0d/%0d want 0/0", bus.stall_cnt, bus.redir_cnt); end
  endtask

  task automatic test_async_reset();
    bus.jump = 1; bus.jump_tgt = 10'h050;
    @(negedge clk);
    bus.jump = 0; bus.load_use = 1;
    @(negedge clk);
    bus.load_use = 0; bus.halt_req = 1; bus.halt_pc = 10'h077;
    @(negedge clk);
    bus.halt_req = 0;
    #1;
    compared++; if (bus.halted !== 1'b1 || bus.stall_cnt !== 4'd2 || bus.redir_cnt !== 4'd1) begin mismatched++;
      $display("FAIL pre_rst: got h=%0h s=%0d r=%0d want 1/2/1", bus.halted, bus.stall_cnt, bus.redir_cnt); end
    #1 rst = 1'b1;
    #1;
    compared++; if (bus.halted !== 1'b0 || bus.stall_cnt !== 4'd0 || bus.redir_cnt !== 4'd0) begin mismatched++;
      $display("FAIL async_rst: got h=%0h s=%0d r=%0d want 0/0/0", bus.halted, bus.stall_cnt, bus.redir_cnt); end
    @(negedge clk);
    rst = 1'b0; bus.pc_4 = 10'h001;
    #1;
    compared++; if (bus.pc_en !== 1'b1 || bus.pc_new !== 10'h001) begin mismatched++;
      $display("FAIL post_rst: got en=%0h pc=%0h want 1/1", bus.pc_en, bus.pc_new); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_idle();
    test_load_use_jump();
    test_branch_priority();
    test_mem_wait_halt_resume();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
